down_count_monitor: RTL

//  Downstream checker/consumer of the mod-8 down counter's count bus.
//  - Tracks each sampled value, classifies steps as hold, legal decrement, wrap (0->MAX) or illegal.
//  - Counts wraps and pushes WRAP/ILLEGAL events into a 2-entry queue drained by valid/ready.
//  - Feeds the status/interrupt logic that sits after the counter.

---
 rtl/down_count_monitor_pkg.sv | 16 +
 rtl/down_count_monitor_fifo.sv | 59 +++++
 rtl/down_count_monitor.sv | 114 +++++++++++
 3 files changed

// File: rtl/down_count_monitor_pkg.sv
// Shared types for the mod-8 down-counter monitor: FSM states and event codes.
package down_count_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    TRACK = 2'd2,
    ERROR = 2'd3
  } mon_state_t;

  typedef enum logic [1:0] {
    EVT_WRAP    = 2'b01,
    EVT_ILLEGAL = 2'b10
  } evt_type_t;

endpackage

// File: rtl/down_count_monitor_fifo.sv
// Two-entry event FIFO; head register drives the outputs, reads as zero when empty.
module down_count_monitor_fifo #(
  parameter int DW = 5
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [DW-1:0] d0_q, d0_d, d1_q, d1_d;
  logic [1:0]    cnt_q, cnt_d, cnt_mid;
  logic          pop_eff, push_ok;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign head_o  = empty_o ? '0 : d0_q;

  always_comb begin
    d0_d    = d0_q;
    d1_d    = d1_q;
    pop_eff = pop_i && !empty_o;
    // A pop frees a slot before the push lands, so push into a full FIFO is legal with a pop.
    push_ok = push_i && (!full_o || pop_eff);
    cnt_mid = cnt_q - {1'b0, pop_eff};
    cnt_d   = cnt_mid + {1'b0, push_ok};
    if (pop_eff) begin
      d0_d = d1_q;
      d1_d = '0;
    end
    if (push_ok) begin
      if (cnt_mid == 2'd0) d0_d = push_data_i;
      else                 d1_d = push_data_i;
    end
    if (flush_i) begin
      cnt_d = 2'd0;
      d0_d  = '0;
      d1_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 2'd0;
      d0_q  <= '0;
      d1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      d0_q  <= d0_d;
      d1_q  <= d1_d;
    end
  end

endmodule

// File: rtl/down_count_monitor.sv
// Monitors a mod-2**WIDTH down counter: classifies steps, counts wraps, queues WRAP/ILLEGAL events.
module down_count_monitor
  import down_count_monitor_pkg::*;
#(
  parameter int WIDTH      = 3,
  parameter int WRAP_CNT_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  clear_i,
  input  logic [WIDTH-1:0]      count_i,
  output logic                  evt_valid_o,
  input  logic                  evt_ready_i,
  output logic [1:0]            evt_type_o,
  output logic [WIDTH-1:0]      evt_count_o,
  output logic [WRAP_CNT_W-1:0] wrap_cnt_o,
  output logic                  err_sticky_o,
  output logic                  ovf_sticky_o
);

  localparam logic [WIDTH-1:0] MAX = '1;

  mon_state_t            state_q, state_d;
  logic [WIDTH-1:0]      prev_q, prev_d;
  logic [WRAP_CNT_W-1:0] wrap_q, wrap_d;
  logic                  err_q, err_d, ovf_q, ovf_d;
  logic                  push, pop, full, empty;
  evt_type_t             push_type;
  logic [WIDTH+1:0]      head;

  assign pop          = evt_ready_i && !empty;
  assign evt_valid_o  = !empty;
  assign evt_type_o   = head[WIDTH+1:WIDTH];
  assign evt_count_o  = head[WIDTH-1:0];
  assign wrap_cnt_o   = wrap_q;
  assign err_sticky_o = err_q;
  assign ovf_sticky_o = ovf_q;

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    wrap_d    = wrap_q;
    err_d     = err_q;
    ovf_d     = ovf_q;
    push      = 1'b0;
    push_type = EVT_WRAP;
    if (clear_i) begin
      // clear overrides anything classified this cycle
      wrap_d  = '0;
      err_d   = 1'b0;
      ovf_d   = 1'b0;
      state_d = enable_i ? ARM : IDLE;
    end else if (!enable_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          prev_d  = count_i;
          state_d = TRACK;
        end
        TRACK: begin
          if (count_i == prev_q) begin
            prev_d = prev_q;
          end else if (prev_q != '0 && count_i == prev_q - WIDTH'(1)) begin
            prev_d = count_i;
          end else if (prev_q == '0 && count_i == MAX) begin
            if (wrap_q != '1) wrap_d = wrap_q + WRAP_CNT_W'(1);
            push   = 1'b1;
            prev_d = count_i;
          end else begin
            push      = 1'b1;
            push_type = EVT_ILLEGAL;
            err_d     = 1'b1;
            state_d   = ERROR;
          end
        end
        ERROR:   state_d = ERROR;
        default: state_d = IDLE;
      endcase
      if (push && full && !pop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      prev_q  <= '0;
      wrap_q  <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  down_count_monitor_fifo #(.DW(WIDTH + 2)) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (clear_i),
    .push_i      (push),
    .push_data_i ({push_type, count_i}),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty)
  );

endmodule
